// File: rtl/fe_request_buffer.sv
// fe_request_buffer
// Buffers requester transactions in a small FIFO and issues them one at a
// time to a cache front end, returning a one-cycle completion pulse with the
// read data, hit flag and request type. Keeps saturating hit/miss counters.
//
// Ports
//   clk_i, reset_i               clock, synchronous active-high reset
//   req_valid_i / req_ready_o    requester handshake
//   req_address_i, req_write_data_i, req_write_i   request fields
//   rsp_valid_o                  completion pulse
//   rsp_read_data_o, rsp_hit_o, rsp_write_o        completion fields (held)
//   cache_address_o, cache_write_data_o, cache_read_write_select_o
//                                cache request fields (held from issue)
//   cache_address_valid_o, cache_write_data_valid_o  one-cycle strobes
//   cache_port_ready_i, cache_read_data_i, cache_read_data_valid_i,
//   cache_write_done_i, cache_hit_i                 cache status
//   clear_stats_i                counter clear
//   hit_count_o, miss_count_o    saturating completion counters
module fe_request_buffer #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] req_address_i,
  input  logic [DATA_WIDTH-1:0]    req_write_data_i,
  input  logic                     req_write_i,
  output logic                     rsp_valid_o,
  output logic [DATA_WIDTH-1:0]    rsp_read_data_o,
  output logic                     rsp_hit_o,
  output logic                     rsp_write_o,
  output logic [ADDRESS_WIDTH-1:0] cache_address_o,
  output logic [DATA_WIDTH-1:0]    cache_write_data_o,
  output logic                     cache_read_write_select_o,
  output logic                     cache_address_valid_o,
  output logic                     cache_write_data_valid_o,
  input  logic                     cache_port_ready_i,
  input  logic [DATA_WIDTH-1:0]    cache_read_data_i,
  input  logic                     cache_read_data_valid_i,
  input  logic                     cache_write_done_i,
  input  logic                     cache_hit_i,
  input  logic                     clear_stats_i,
  output logic [15:0]              hit_count_o,
  output logic [15:0]              miss_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  // Request storage; entries are never reset, only pointers/count are.
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
  logic                     we_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  state_t           state_reg, state_next;

  logic push, pop, issue_fire, complete_fire;

  logic [ADDRESS_WIDTH-1:0] cache_address_reg;
  logic [DATA_WIDTH-1:0]    cache_write_data_reg;
  logic                     cache_rw_reg, addr_valid_reg, data_valid_reg;
  logic                     rsp_valid_reg, rsp_hit_reg, rsp_write_reg;
  logic [DATA_WIDTH-1:0]    rsp_read_data_reg;
  logic [15:0]              hit_count_reg, miss_count_reg;

  // Completion is signalled by cache_port_ready_i in WAIT; the per-type
  // done/valid qualifiers are not needed to sequence the buffer.
  logic unused_status;
  assign unused_status = cache_read_data_valid_i | cache_write_done_i;

  assign req_ready_o = (count_reg != CNT_W'(DEPTH));
  assign push        = req_valid_i && req_ready_o;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (count_reg != '0 && cache_port_ready_i) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (cache_port_ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    issue_fire    = (state_reg == ST_IDLE) && (count_reg != '0) && cache_port_ready_i;
    complete_fire = (state_reg == ST_WAIT) && cache_port_ready_i;
    pop           = complete_fire;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= req_address_i;
      data_mem[wr_ptr_reg] <= req_write_data_i;
      we_mem[wr_ptr_reg]   <= req_write_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Cache request fields: loaded from the head at issue, held until the next
  // issue. The held select bit also tells the completion whether it was a read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cache_address_reg    <= '0;
      cache_write_data_reg <= '0;
      cache_rw_reg         <= 1'b0;
      addr_valid_reg       <= 1'b0;
      data_valid_reg       <= 1'b0;
    end else begin
      addr_valid_reg <= issue_fire;
      data_valid_reg <= issue_fire && we_mem[rd_ptr_reg];
      if (issue_fire) begin
        cache_address_reg    <= addr_mem[rd_ptr_reg];
        cache_write_data_reg <= data_mem[rd_ptr_reg];
        cache_rw_reg         <= we_mem[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rsp_valid_reg     <= 1'b0;
      rsp_read_data_reg <= '0;
      rsp_hit_reg       <= 1'b0;
      rsp_write_reg     <= 1'b0;
    end else begin
      rsp_valid_reg <= complete_fire;
      if (complete_fire) begin
        if (!cache_rw_reg) rsp_read_data_reg <= cache_read_data_i;
        rsp_hit_reg   <= cache_hit_i;
        rsp_write_reg <= cache_rw_reg;
      end
    end
  end

  // Statistics: clear wins over a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_stats_i) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (complete_fire) begin
      if (cache_hit_i) begin
        if (hit_count_reg != 16'hFFFF) hit_count_reg <= hit_count_reg + 16'd1;
      end else begin
        if (miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end

  assign cache_address_o           = cache_address_reg;
  assign cache_write_data_o        = cache_write_data_reg;
  assign cache_read_write_select_o = cache_rw_reg;
  assign cache_address_valid_o     = addr_valid_reg;
  assign cache_write_data_valid_o  = data_valid_reg;
  assign rsp_valid_o               = rsp_valid_reg;
  assign rsp_read_data_o           = rsp_read_data_reg;
  assign rsp_hit_o                 = rsp_hit_reg;
  assign rsp_write_o               = rsp_write_reg;
  assign hit_count_o               = hit_count_reg;
  assign miss_count_o              = miss_count_reg;

endmodule

// File: tb/tb_fe_request_buffer.sv
// Testbench for fe_request_buffer: directed stimulus with a scoreboard.
// Expected issues and completions are queued when a request is pushed; two
// monitors pop and compare whenever the DUT strobes the cache or completes.
module tb_fe_request_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_address_i;
  logic [15:0] req_write_data_i;
  logic        req_write_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_read_data_o;
  logic        rsp_hit_o;
  logic        rsp_write_o;
  logic [7:0]  cache_address_o;
  logic [15:0] cache_write_data_o;
  logic        cache_read_write_select_o;
  logic        cache_address_valid_o;
  logic        cache_write_data_valid_o;
  logic        cache_port_ready_i;
  logic [15:0] cache_read_data_i;
  logic        cache_read_data_valid_i;
  logic        cache_write_done_i;
  logic        cache_hit_i;
  logic        clear_stats_i;
  logic [15:0] hit_count_o;
  logic [15:0] miss_count_o;

  int checks = 0;
  int fails  = 0;

  typedef struct { logic [7:0] a; logic [15:0] d; logic w; } iss_t;
  typedef struct { logic [15:0] d; logic h; logic w; } rsp_t;
  iss_t exp_iss[$];
  rsp_t exp_rsp[$];

  fe_request_buffer #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_address_i(req_address_i), .req_write_data_i(req_write_data_i),
    .req_write_i(req_write_i),
    .rsp_valid_o(rsp_valid_o), .rsp_read_data_o(rsp_read_data_o),
    .rsp_hit_o(rsp_hit_o), .rsp_write_o(rsp_write_o),
    .cache_address_o(cache_address_o), .cache_write_data_o(cache_write_data_o),
    .cache_read_write_select_o(cache_read_write_select_o),
    .cache_address_valid_o(cache_address_valid_o),
    .cache_write_data_valid_o(cache_write_data_valid_o),
    .cache_port_ready_i(cache_port_ready_i), .cache_read_data_i(cache_read_data_i),
    .cache_read_data_valid_i(cache_read_data_valid_i),
    .cache_write_done_i(cache_write_done_i), .cache_hit_i(cache_hit_i),
    .clear_stats_i(clear_stats_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Cache model: memory initialised to A000+addr, 0x12 holds BEEF.
  logic [15:0] cmem [256];
  initial begin
    for (int i = 0; i < 256; i++) cmem[i] = 16'hA000 + 16'(i);
    cmem[8'h12] = 16'hBEEF;
  end
  always @(posedge clk_i)
    if (cache_address_valid_o && cache_write_data_valid_o)
      cmem[cache_address_o] <= cache_write_data_o;
  assign cache_read_data_i       = cmem[cache_address_o];
  assign cache_read_data_valid_i = 1'b1;
  assign cache_write_done_i      = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue monitor
  always @(negedge clk_i) begin : mon_iss
    iss_t e;
    if (!reset_i) begin
      if (cache_address_valid_o) begin
        if (exp_iss.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_issue: got addr %0h expected no issue", cache_address_o);
        end else begin
          e = exp_iss.pop_front();
          chk("iss_addr", 32'(cache_address_o), 32'(e.a));
          chk("iss_wdata", 32'(cache_write_data_o), 32'(e.d));
          chk("iss_wdv", 32'(cache_write_data_valid_o), 32'(e.w));
          chk("iss_rw", 32'(cache_read_write_select_o), 32'(e.w));
          $display("issue addr=%0h wdata=%0h we=%0b", cache_address_o, cache_write_data_o, cache_read_write_select_o);
        end
      end else if (cache_write_data_valid_o) begin
        checks++; fails++;
        $display("FAIL stray_wdv: got 1 expected 0");
      end
    end
  end

  // Completion monitor
  always @(negedge clk_i) begin : mon_rsp
    rsp_t e;
    if (!reset_i && rsp_valid_o) begin
      if (exp_rsp.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_rsp: got data %0h expected no response", rsp_read_data_o);
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_data", 32'(rsp_read_data_o), 32'(e.d));
        chk("rsp_hit", 32'(rsp_hit_o), 32'(e.h));
        chk("rsp_write", 32'(rsp_write_o), 32'(e.w));
        $display("rsp data=%0h hit=%0b write=%0b", rsp_read_data_o, rsp_hit_o, rsp_write_o);
      end
    end
  end

  task automatic push_req(input logic [7:0] a, input logic [15:0] d, input logic w,
                          input logic [15:0] rd, input logic h,
                          input logic want_iss, input logic want_rsp);
    iss_t ei;
    rsp_t er;
    int n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 200) begin @(negedge clk_i); n++; end
    if (!req_ready_o) chk("push_timeout", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_address_i = a; req_write_data_i = d; req_write_i = w;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    ei.a = a; ei.d = d; ei.w = w;
    er.d = rd; er.h = h; er.w = w;
    if (want_iss) exp_iss.push_back(ei);
    if (want_rsp) exp_rsp.push_back(er);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 300) begin @(negedge clk_i); n++; end
    chk("drain", 32'(exp_rsp.size()), 32'd0);
  endtask

  task automatic wait_strobe();
    int n = 0;
    @(negedge clk_i);
    while (!cache_address_valid_o && n < 50) begin @(negedge clk_i); n++; end
    chk("strobe_seen", 32'(cache_address_valid_o), 32'd1);
  endtask

  initial begin
    int n;
    reset_i = 1'b1; req_valid_i = 1'b0; req_address_i = '0; req_write_data_i = '0;
    req_write_i = 1'b0; cache_port_ready_i = 1'b1; cache_hit_i = 1'b0; clear_stats_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_data", 32'(rsp_read_data_o), 32'd0);
    chk("rst_cache_addr", 32'(cache_address_o), 32'd0);
    chk("rst_strobes", 32'({cache_address_valid_o, cache_write_data_valid_o}), 32'd0);
    chk("rst_counts", 32'({hit_count_o, miss_count_o}), 32'd0);

    // Single read miss
    cache_hit_i = 1'b0;
    push_req(8'h12, 16'h0, 1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b1);
    wait_drain();
    chk("single_miss", 32'(miss_count_o), 32'd1);
    chk("single_hit", 32'(hit_count_o), 32'd0);

    // Fill the FIFO while the cache is stalled
    @(negedge clk_i); cache_port_ready_i = 1'b0; cache_hit_i = 1'b1;
    for (int i = 1; i <= 4; i++)
      push_req(8'(i), 16'h0, 1'b0, 16'hA000 + 16'(i), 1'b1, 1'b1, 1'b1);
    chk("full_ready", 32'(req_ready_o), 32'd0);
    chk("full_count", 32'(dut.count_reg), 32'd4);
    @(negedge clk_i); req_valid_i = 1'b1; req_address_i = 8'h20;
    repeat (2) @(negedge clk_i);
    chk("held_ready", 32'(req_ready_o), 32'd0);
    req_valid_i = 1'b0;
    chk("held_count", 32'(dut.count_reg), 32'd4);
    @(negedge clk_i); cache_port_ready_i = 1'b1;
    n = 0;
    while (!rsp_valid_o && n < 50) begin @(negedge clk_i); n++; end
    chk("ready_after_pop", 32'(req_ready_o), 32'd1);
    wait_drain();
    chk("fill_hits", 32'(hit_count_o), 32'd4);

    // Write then read the same address
    cache_hit_i = 1'b0;
    push_req(8'h05, 16'h1234, 1'b1, 16'hA004, 1'b0, 1'b1, 1'b1);
    push_req(8'h05, 16'h0, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b1);
    wait_drain();
    chk("order_miss", 32'(miss_count_o), 32'd3);

    // Push in the completion cycle with two entries queued
    cache_hit_i = 1'b1;
    @(negedge clk_i); cache_port_ready_i = 1'b0;
    push_req(8'h06, 16'h0, 1'b0, 16'hA006, 1'b1, 1'b1, 1'b1);
    push_req(8'h07, 16'h0, 1'b0, 16'hA007, 1'b1, 1'b1, 1'b1);
    @(negedge clk_i); cache_port_ready_i = 1'b1;
    wait_strobe();
    cache_port_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("pre_pp_count", 32'(dut.count_reg), 32'd2);
    cache_port_ready_i = 1'b1;
    req_valid_i = 1'b1; req_address_i = 8'h08; req_write_data_i = 16'h0; req_write_i = 1'b0;
    exp_iss.push_back('{a: 8'h08, d: 16'h0, w: 1'b0});
    exp_rsp.push_back('{d: 16'hA008, h: 1'b1, w: 1'b0});
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    chk("count_push_pop", 32'(dut.count_reg), 32'd2);
    wait_drain();
    chk("pp_hits", 32'(hit_count_o), 32'd7);

    // Saturation from a preloaded hit count
    @(negedge clk_i); dut.hit_count_reg = 16'hFFFE;
    for (int i = 9; i <= 11; i++)
      push_req(8'(i), 16'h0, 1'b0, 16'hA000 + 16'(i), 1'b1, 1'b1, 1'b1);
    wait_drain();
    chk("sat_hits", 32'(hit_count_o), 32'hFFFF);
    @(negedge clk_i); cache_port_ready_i = 1'b0;
    push_req(8'h0C, 16'h0, 1'b0, 16'hA00C, 1'b1, 1'b1, 1'b1);
    @(negedge clk_i); cache_port_ready_i = 1'b1;
    wait_strobe();
    cache_port_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    cache_port_ready_i = 1'b1; clear_stats_i = 1'b1;
    @(posedge clk_i);
    #1 clear_stats_i = 1'b0;
    chk("clear_hits", 32'(hit_count_o), 32'd0);
    chk("clear_misses", 32'(miss_count_o), 32'd0);
    wait_drain();

    // Reset while waiting on the cache with three requests queued
    @(negedge clk_i); cache_port_ready_i = 1'b0;
    push_req(8'h30, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    push_req(8'h31, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    push_req(8'h32, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i); cache_port_ready_i = 1'b1;
    wait_strobe();
    cache_port_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_count", 32'(dut.count_reg), 32'd3);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    chk("midrst_count", 32'(dut.count_reg), 32'd0);
    chk("midrst_ready", 32'(req_ready_o), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("midrst_strobes", 32'({cache_address_valid_o, cache_write_data_valid_o}), 32'd0);
    chk("midrst_addr", 32'(cache_address_o), 32'd0);
    @(negedge clk_i); cache_port_ready_i = 1'b1;
    repeat (15) @(negedge clk_i);

    chk("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
